mem_req_arbiter: RTL and testbench

- Sits directly upstream of ideal_mem in the multi-cycle MIPS core.
- Accepts instruction-fetch and load/store requests from the CPU over valid/ready handshakes and arbitrates them onto ideal_mem's write port and two read ports.
- Inserts a programmable access latency to model non-ideal memory.
- Returns read data and write acknowledgements through registered one-cycle response pulses.

---
 rtl/mem_req_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: single-outstanding arbiter between the CPU fetch/load-store
// request channels and ideal_mem, with a programmable wait before each access.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready to accept; data request has priority over fetch
// WAIT   | counting down LATENCY cycles before the memory access
// ACCESS | one cycle of memory strobes; read data captured at its end
// RESP   | one-cycle response pulse on the requesting channel
module mem_req_arbiter #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int LATENCY        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inst_req_valid,
    output logic                      inst_req_ready,
    input  logic [31:0]               inst_addr,
    output logic                      inst_resp_valid,
    output logic [31:0]               inst_rdata,
    input  logic                      data_req_valid,
    output logic                      data_req_ready,
    input  logic                      data_wen,
    input  logic [31:0]               data_addr,
    input  logic [31:0]               data_wdata,
    output logic                      data_resp_valid,
    output logic [31:0]               data_rdata,
    output logic [MEM_ADDR_WIDTH-1:0] mem_Waddr,
    output logic [MEM_ADDR_WIDTH-1:0] mem_Raddr1,
    output logic [MEM_ADDR_WIDTH-1:0] mem_Raddr2,
    output logic                      mem_Wren,
    output logic                      mem_Rden1,
    output logic                      mem_Rden2,
    output logic [31:0]               mem_Wdata,
    input  logic [31:0]               mem_Rdata1,
    input  logic [31:0]               mem_Rdata2
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [3:0] LAT = 4'(LATENCY);

    logic [1:0]                r_state;
    logic [3:0]                r_cnt;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]               r_wdata;
    logic                      r_wen;
    logic                      r_src;       // 1 = data channel, 0 = fetch
    logic [31:0]               r_inst_rdata;
    logic [31:0]               r_data_rdata;
    logic                      r_inst_resp;
    logic                      r_data_resp;

    logic w_idle;
    logic w_access;
    logic w_data_hs;
    logic w_inst_hs;
    logic w_unused_addr_bits;

    // Ready is suppressed while rst is held so nothing can handshake in reset.
    assign w_idle         = (r_state == S_IDLE) && !rst;
    assign data_req_ready = w_idle;
    assign inst_req_ready = w_idle && !data_req_valid;
    assign w_data_hs      = data_req_valid && data_req_ready;
    assign w_inst_hs      = inst_req_valid && inst_req_ready;
    assign w_access       = (r_state == S_ACCESS);

    // Byte-offset and upper address bits are intentionally discarded (wrap).
    assign w_unused_addr_bits = ^{inst_addr[31:MEM_ADDR_WIDTH+2], inst_addr[1:0],
                                  data_addr[31:MEM_ADDR_WIDTH+2], data_addr[1:0]};

    assign mem_Rden1  = w_access && !r_src;
    assign mem_Rden2  = w_access && r_src && !r_wen;
    assign mem_Wren   = w_access && r_src && r_wen;
    assign mem_Waddr  = r_addr;
    assign mem_Raddr1 = r_addr;
    assign mem_Raddr2 = r_addr;
    assign mem_Wdata  = r_wdata;

    assign inst_resp_valid = r_inst_resp;
    assign data_resp_valid = r_data_resp;
    assign inst_rdata      = r_inst_rdata;
    assign data_rdata      = r_data_rdata;

    // Transaction FSM: grant, latch the request, count latency, access, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_wen   <= 1'b0;
            r_src   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_data_hs) begin
                        r_addr  <= data_addr[MEM_ADDR_WIDTH+1:2];
                        r_wdata <= data_wdata;
                        r_wen   <= data_wen;
                        r_src   <= 1'b1;
                        r_cnt   <= LAT;
                        r_state <= (LAT == 4'd0) ? S_ACCESS : S_WAIT;
                    end else if (w_inst_hs) begin
                        r_addr  <= inst_addr[MEM_ADDR_WIDTH+1:2];
                        r_wen   <= 1'b0;
                        r_src   <= 1'b0;
                        r_cnt   <= LAT;
                        r_state <= (LAT == 4'd0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: r_state <= S_RESP;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Response pulses and read-data capture at the end of the ACCESS cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst_resp  <= 1'b0;
            r_data_resp  <= 1'b0;
            r_inst_rdata <= 32'd0;
            r_data_rdata <= 32'd0;
        end else begin
            r_inst_resp <= w_access && !r_src;
            r_data_resp <= w_access && r_src;
            if (w_access && !r_src) begin
                r_inst_rdata <= mem_Rdata1;
            end
            if (w_access && r_src) begin
                r_data_rdata <= r_wen ? 32'd0 : mem_Rdata2;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: three instances (LATENCY 2, 0, 5), each
// backed by its own behavioural ideal_mem model.
module tb_mem_req_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;

    logic        inst_req_valid  [3];
    logic        inst_req_ready  [3];
    logic [31:0] inst_addr       [3];
    logic        inst_resp_valid [3];
    logic [31:0] inst_rdata      [3];
    logic        data_req_valid  [3];
    logic        data_req_ready  [3];
    logic        data_wen        [3];
    logic [31:0] data_addr       [3];
    logic [31:0] data_wdata      [3];
    logic        data_resp_valid [3];
    logic [31:0] data_rdata      [3];
    logic [9:0]  mem_Waddr       [3];
    logic [9:0]  mem_Raddr1      [3];
    logic [9:0]  mem_Raddr2      [3];
    logic        mem_Wren        [3];
    logic        mem_Rden1       [3];
    logic        mem_Rden2       [3];
    logic [31:0] mem_Wdata       [3];
    logic [31:0] mem_Rdata1      [3];
    logic [31:0] mem_Rdata2      [3];

    int n_checks = 0;
    int n_errors = 0;

    localparam int LATS [3] = '{2, 0, 5};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] mem [1024];

        mem_req_arbiter #(.MEM_ADDR_WIDTH(10), .LATENCY(LATS[g])) u_dut (
            .clk             (clk),
            .rst             (rst),
            .inst_req_valid  (inst_req_valid[g]),
            .inst_req_ready  (inst_req_ready[g]),
            .inst_addr       (inst_addr[g]),
            .inst_resp_valid (inst_resp_valid[g]),
            .inst_rdata      (inst_rdata[g]),
            .data_req_valid  (data_req_valid[g]),
            .data_req_ready  (data_req_ready[g]),
            .data_wen        (data_wen[g]),
            .data_addr       (data_addr[g]),
            .data_wdata      (data_wdata[g]),
            .data_resp_valid (data_resp_valid[g]),
            .data_rdata      (data_rdata[g]),
            .mem_Waddr       (mem_Waddr[g]),
            .mem_Raddr1      (mem_Raddr1[g]),
            .mem_Raddr2      (mem_Raddr2[g]),
            .mem_Wren        (mem_Wren[g]),
            .mem_Rden1       (mem_Rden1[g]),
            .mem_Rden2       (mem_Rden2[g]),
            .mem_Wdata       (mem_Wdata[g]),
            .mem_Rdata1      (mem_Rdata1[g]),
            .mem_Rdata2      (mem_Rdata2[g])
        );

        // ideal_mem model: synchronous write, asynchronous reads, preload on mem_init.
        always @(posedge clk) begin
            if (mem_init) begin
                for (int k = 0; k < 1024; k++) mem[k] <= 32'd0;
                mem[0]    <= 32'h1111_1111;
                mem[1]    <= 32'h0800_0004;
                mem[3]    <= 32'hDEAD_BEEF;
                mem[4]    <= 32'h241D_0400;
                mem[5]    <= 32'h5555_5555;
                mem[19]   <= 32'h0BAD_F00D;
                mem[1023] <= 32'h3FF3_FF00;
            end else if (mem_Wren[g]) begin
                mem[mem_Waddr[g]] <= mem_Wdata[g];
            end
        end
        assign mem_Rdata1[g] = mem[mem_Raddr1[g]];
        assign mem_Rdata2[g] = mem[mem_Raddr2[g]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        mem_init = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst_req_valid[i] = 1'b1;
            inst_addr[i]      = 32'd0;
            data_req_valid[i] = 1'b1;
            data_wen[i]       = 1'b0;
            data_addr[i]      = 32'd0;
            data_wdata[i]     = 32'd0;
        end
        tick();
        tick();

        // Reset state, with both valids asserted
        for (int i = 0; i < 3; i++) begin
            chk("rst_inst_ready", 32'(inst_req_ready[i]), 32'd0);
            chk("rst_data_ready", 32'(data_req_ready[i]), 32'd0);
            chk("rst_inst_resp", 32'(inst_resp_valid[i]), 32'd0);
            chk("rst_data_resp", 32'(data_resp_valid[i]), 32'd0);
            chk("rst_inst_rdata", inst_rdata[i], 32'd0);
            chk("rst_data_rdata", data_rdata[i], 32'd0);
            chk("rst_enables", 32'({mem_Wren[i], mem_Rden1[i], mem_Rden2[i]}), 32'd0);
        end
        rst      = 1'b0;
        mem_init = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inst_req_valid[i] = 1'b0;
            data_req_valid[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 3; i++) chk("post_rst_inst_ready", 32'(inst_req_ready[i]), 32'd1);

        // Fetch on LATENCY=2 instance
        tick();
        inst_req_valid[0] = 1'b1;
        inst_addr[0]      = 32'h0000_0004;
        #1;
        chk("f_c0_ready", 32'(inst_req_ready[0]), 32'd1);
        chk("f_c0_rden1", 32'(mem_Rden1[0]), 32'd0);
        tick();
        inst_req_valid[0] = 1'b0;
        #1;
        chk("f_c1_ready", 32'(inst_req_ready[0]), 32'd0);
        chk("f_c1_rden1", 32'(mem_Rden1[0]), 32'd0);
        tick();
        chk("f_c2_rden1", 32'(mem_Rden1[0]), 32'd0);
        tick();
        chk("f_c3_rden1", 32'(mem_Rden1[0]), 32'd1);
        chk("f_c3_raddr1", 32'(mem_Raddr1[0]), 32'd1);
        chk("f_c3_other", 32'({mem_Wren[0], mem_Rden2[0]}), 32'd0);
        chk("f_c3_resp", 32'(inst_resp_valid[0]), 32'd0);
        tick();
        chk("f_c4_resp", 32'(inst_resp_valid[0]), 32'd1);
        chk("f_c4_rdata", inst_rdata[0], 32'h0800_0004);
        chk("f_c4_rden1", 32'(mem_Rden1[0]), 32'd0);
        chk("f_c4_ready", 32'(inst_req_ready[0]), 32'd0);
        tick();
        chk("f_c5_resp", 32'(inst_resp_valid[0]), 32'd0);
        chk("f_c5_ready", 32'(inst_req_ready[0]), 32'd1);
        chk("f_c5_rdata_hold", inst_rdata[0], 32'h0800_0004);

        // LATENCY=0: load old value, store 0, load again
        tick();
        data_req_valid[1] = 1'b1;
        data_wen[1]       = 1'b0;
        data_addr[1]      = 32'h0000_000C;
        #1;
        chk("l0_c0_ready", 32'(data_req_ready[1]), 32'd1);
        tick();
        data_req_valid[1] = 1'b0;
        #1;
        chk("l0_c1_rden2", 32'(mem_Rden2[1]), 32'd1);
        chk("l0_c1_raddr2", 32'(mem_Raddr2[1]), 32'd3);
        tick();
        chk("l0_c2_resp", 32'(data_resp_valid[1]), 32'd1);
        chk("l0_c2_rdata", data_rdata[1], 32'hDEAD_BEEF);
        tick();
        data_req_valid[1] = 1'b1;
        data_wen[1]       = 1'b1;
        data_wdata[1]     = 32'd0;
        #1;
        chk("sw_c0_ready", 32'(data_req_ready[1]), 32'd1);
        tick();
        data_req_valid[1] = 1'b0;
        #1;
        chk("sw_c1_wren", 32'(mem_Wren[1]), 32'd1);
        chk("sw_c1_waddr", 32'(mem_Waddr[1]), 32'd3);
        chk("sw_c1_wdata", mem_Wdata[1], 32'd0);
        chk("sw_c1_rden2", 32'(mem_Rden2[1]), 32'd0);
        tick();
        chk("sw_c2_resp", 32'(data_resp_valid[1]), 32'd1);
        chk("sw_c2_rdata", data_rdata[1], 32'd0);
        chk("sw_c2_wren", 32'(mem_Wren[1]), 32'd0);
        chk("sw_mem3", g_dut[1].mem[3], 32'd0);
        tick();
        data_req_valid[1] = 1'b1;
        data_wen[1]       = 1'b0;
        #1;
        chk("lw_c0_ready", 32'(data_req_ready[1]), 32'd1);
        tick();
        data_req_valid[1] = 1'b0;
        data_wdata[1]     = 32'd0;
        tick();
        chk("lw_c2_resp", 32'(data_resp_valid[1]), 32'd1);
        chk("lw_c2_rdata", data_rdata[1], 32'd0);

        // Simultaneous fetch and load on LATENCY=2 instance
        tick();
        inst_req_valid[0] = 1'b1;
        inst_addr[0]      = 32'h0000_0010;
        data_req_valid[0] = 1'b1;
        data_wen[0]       = 1'b0;
        data_addr[0]      = 32'h0000_004C;
        #1;
        chk("arb_c0_data_ready", 32'(data_req_ready[0]), 32'd1);
        chk("arb_c0_inst_ready", 32'(inst_req_ready[0]), 32'd0);
        tick();
        data_req_valid[0] = 1'b0;
        #1;
        chk("arb_c1_inst_ready", 32'(inst_req_ready[0]), 32'd0);
        tick();
        tick();
        chk("arb_c3_rden2", 32'(mem_Rden2[0]), 32'd1);
        chk("arb_c3_raddr2", 32'(mem_Raddr2[0]), 32'd19);
        chk("arb_c3_rden1", 32'(mem_Rden1[0]), 32'd0);
        tick();
        chk("arb_c4_data_resp", 32'(data_resp_valid[0]), 32'd1);
        chk("arb_c4_data_rdata", data_rdata[0], 32'h0BAD_F00D);
        chk("arb_c4_inst_ready", 32'(inst_req_ready[0]), 32'd0);
        tick();
        chk("arb_c5_inst_ready", 32'(inst_req_ready[0]), 32'd1);
        tick();
        inst_req_valid[0] = 1'b0;
        tick();
        tick();
        chk("arb_c8_rden1", 32'(mem_Rden1[0]), 32'd1);
        chk("arb_c8_raddr1", 32'(mem_Raddr1[0]), 32'd4);
        tick();
        chk("arb_c9_inst_resp", 32'(inst_resp_valid[0]), 32'd1);
        chk("arb_c9_inst_rdata", inst_rdata[0], 32'h241D_0400);
        chk("arb_c9_data_hold", data_rdata[0], 32'h0BAD_F00D);

        // Address wrap and misalignment on LATENCY=0 instance
        tick();
        data_req_valid[1] = 1'b1;
        data_addr[1]      = 32'h0000_1003;
        tick();
        data_req_valid[1] = 1'b0;
        #1;
        chk("wrap_raddr2", 32'(mem_Raddr2[1]), 32'h000);
        chk("wrap_rden2", 32'(mem_Rden2[1]), 32'd1);
        tick();
        chk("wrap_rdata", data_rdata[1], 32'h1111_1111);
        tick();
        data_req_valid[1] = 1'b1;
        data_addr[1]      = 32'h0000_0FFD;
        tick();
        data_req_valid[1] = 1'b0;
        #1;
        chk("top_raddr2", 32'(mem_Raddr2[1]), 32'h3FF);
        tick();
        chk("top_rdata", data_rdata[1], 32'h3FF3_FF00);

        // Reset during WAIT of a pending store on LATENCY=5 instance
        tick();
        data_req_valid[2] = 1'b1;
        data_wen[2]       = 1'b1;
        data_addr[2]      = 32'h0000_0014;
        data_wdata[2]     = 32'hCAFE_F00D;
        #1;
        chk("rw_c0_ready", 32'(data_req_ready[2]), 32'd1);
        tick();
        data_req_valid[2] = 1'b0;
        #1;
        chk("rw_c1_ready", 32'(data_req_ready[2]), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("rw_rst_ready", 32'(data_req_ready[2]), 32'd0);
        chk("rw_rst_wren", 32'(mem_Wren[2]), 32'd0);
        chk("rw_rst_data_rdata1", data_rdata[1], 32'd0);
        chk("rw_rst_inst_rdata0", inst_rdata[0], 32'd0);
        chk("rw_rst_data_rdata0", data_rdata[0], 32'd0);
        tick();
        rst = 1'b0;
        #1;
        for (int c = 0; c < 10; c++) begin
            chk("rw_no_wren", 32'(mem_Wren[2]), 32'd0);
            chk("rw_no_resp", 32'(data_resp_valid[2]), 32'd0);
            tick();
        end
        chk("rw_mem5", g_dut[2].mem[5], 32'h5555_5555);
        chk("rw_ready_back", 32'(data_req_ready[2]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
